// File: rtl/axi_memory_reader_cmd_gen.sv
// Packet command generator: on START, pushes {address, size} commands into a
// first-word-fall-through FIFO that the AXI memory reader drains.
module axi_memory_reader_cmd_gen #(
   parameter int ADDR_WIDTH = 32,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          CLK,
   input  logic                          RESET,
   input  logic                          START,
   input  logic                          STOP,
   input  logic [ADDR_WIDTH-1:0]         BASE_ADDR,
   input  logic [63:0]                   PKT_SIZE,
   input  logic [ADDR_WIDTH-1:0]         PKT_STRIDE,
   input  logic [31:0]                   PKT_COUNT,
   output logic [ADDR_WIDTH-1:0]         CMD_ADDRESS,
   output logic [63:0]                   CMD_SIZE,
   output logic                          CMD_EMPTY,
   input  logic                          CMD_RDEN,
   output logic [$clog2(FIFO_DEPTH):0]   CMD_LEVEL,
   output logic                          GEN_BUSY,
   output logic [31:0]                   ISSUED_COUNT,
   output logic [31:0]                   DONE_COUNT
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int ENTRY_W = ADDR_WIDTH + 64;
   localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_GENERATE = 2'd1;
   localparam logic [1:0] ST_DRAIN    = 2'd2;

   logic [1:0]            state_reg, state_next;
   logic [ADDR_WIDTH-1:0] next_addr_reg;
   logic [ADDR_WIDTH-1:0] stride_reg;
   logic [63:0]           size_reg;
   logic [31:0]           count_reg;
   logic [31:0]           remaining_reg;
   logic [PTR_W-1:0]      wr_ptr_reg;
   logic [PTR_W-1:0]      rd_ptr_reg;
   logic [LVL_W-1:0]      level_reg, level_next;
   logic [31:0]           issued_reg;
   logic [31:0]           done_reg;
   logic [ENTRY_W-1:0]    mem [FIFO_DEPTH];
   logic [ENTRY_W-1:0]    head;

   logic accept_start;
   logic push;
   logic pop;
   logic last_push;

   // Push eligibility looks only at registered level, so a pop from full
   // cannot open a slot for a push on the same edge.
   assign accept_start = (state_reg == ST_IDLE) && START;
   assign push         = (state_reg == ST_GENERATE) && !STOP && (level_reg < DEPTH_LVL);
   assign pop          = CMD_RDEN && (level_reg != '0);
   assign last_push    = push && (count_reg != '0) && (remaining_reg == 32'd1);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:     if (START) state_next = ST_GENERATE;
         ST_GENERATE: if (STOP || last_push) state_next = ST_DRAIN;
         ST_DRAIN:    if (level_reg == '0) state_next = ST_IDLE;
         default:     state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      level_next = level_reg;
      case ({push, pop})
         2'b10:   level_next = level_reg + 1'b1;
         2'b01:   level_next = level_reg - 1'b1;
         default: level_next = level_reg;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_reg     <= ST_IDLE;
         next_addr_reg <= '0;
         stride_reg    <= '0;
         size_reg      <= '0;
         count_reg     <= '0;
         remaining_reg <= '0;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         level_reg     <= '0;
         issued_reg    <= '0;
         done_reg      <= '0;
      end else begin
         state_reg <= state_next;
         level_reg <= level_next;
         if (accept_start) begin
            next_addr_reg <= BASE_ADDR;
            stride_reg    <= PKT_STRIDE;
            size_reg      <= PKT_SIZE;
            count_reg     <= PKT_COUNT;
            remaining_reg <= PKT_COUNT;
            issued_reg    <= '0;
            done_reg      <= '0;
         end else begin
            if (push) begin
               next_addr_reg <= next_addr_reg + stride_reg;
               wr_ptr_reg    <= wr_ptr_reg + 1'b1;
               issued_reg    <= issued_reg + 32'd1;
               if (count_reg != '0)
                  remaining_reg <= remaining_reg - 32'd1;
            end
            if (pop) begin
               rd_ptr_reg <= rd_ptr_reg + 1'b1;
               done_reg   <= done_reg + 32'd1;
            end
         end
      end
   end

   // Storage carries no reset; the level gates every read of it.
   always_ff @(posedge CLK) begin
      if (push)
         mem[wr_ptr_reg] <= {next_addr_reg, size_reg};
   end

   assign head         = mem[rd_ptr_reg];
   assign CMD_EMPTY    = (level_reg == '0);
   assign CMD_ADDRESS  = CMD_EMPTY ? '0 : head[ENTRY_W-1:64];
   assign CMD_SIZE     = CMD_EMPTY ? '0 : head[63:0];
   assign CMD_LEVEL    = level_reg;
   assign GEN_BUSY     = (state_reg != ST_IDLE);
   assign ISSUED_COUNT = issued_reg;
   assign DONE_COUNT   = done_reg;

endmodule

// File: tb/tb_axi_memory_reader_cmd_gen.sv
// Scoreboard bench: stimulus queues expected commands, a negedge monitor pops
// the reader side and compares every head it consumes.
module tb_axi_memory_reader_cmd_gen;

   logic        CLK;
   logic        RESET;
   logic        START;
   logic        STOP;
   logic [31:0] BASE_ADDR;
   logic [63:0] PKT_SIZE;
   logic [31:0] PKT_STRIDE;
   logic [31:0] PKT_COUNT;
   logic [31:0] CMD_ADDRESS;
   logic [63:0] CMD_SIZE;
   logic        CMD_EMPTY;
   logic        CMD_RDEN;
   logic [4:0]  CMD_LEVEL;
   logic        GEN_BUSY;
   logic [31:0] ISSUED_COUNT;
   logic [31:0] DONE_COUNT;

   axi_memory_reader_cmd_gen #(.ADDR_WIDTH(32), .FIFO_DEPTH(16)) dut (
      .CLK(CLK), .RESET(RESET), .START(START), .STOP(STOP),
      .BASE_ADDR(BASE_ADDR), .PKT_SIZE(PKT_SIZE), .PKT_STRIDE(PKT_STRIDE),
      .PKT_COUNT(PKT_COUNT), .CMD_ADDRESS(CMD_ADDRESS), .CMD_SIZE(CMD_SIZE),
      .CMD_EMPTY(CMD_EMPTY), .CMD_RDEN(CMD_RDEN), .CMD_LEVEL(CMD_LEVEL),
      .GEN_BUSY(GEN_BUSY), .ISSUED_COUNT(ISSUED_COUNT), .DONE_COUNT(DONE_COUNT)
   );

   typedef struct {
      logic [31:0] addr;
      logic [63:0] size;
   } cmd_t;

   cmd_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   pop_mode = 0;     // 0 none, 1 always, 2 random, 3 manual
   logic rden_manual = 1'b0;
   logic mon_rd;
   cmd_t mon_e;

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #2000000;
      $display("FAIL timeout global_limit actual=running required=finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Reader model: decides the pop for the coming edge and checks the head it takes.
   always @(negedge CLK) begin
      case (pop_mode)
         0:       mon_rd = 1'b0;
         1:       mon_rd = 1'b1;
         2:       mon_rd = 1'($urandom_range(0, 1));
         default: mon_rd = rden_manual;
      endcase
      if (mon_rd && !CMD_EMPTY && !RESET) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL head_unexpected actual=0x%0h required=none", CMD_ADDRESS);
         end else begin
            mon_e = exp_q.pop_front();
            check("head_addr", 64'(CMD_ADDRESS), 64'(mon_e.addr));
            check("head_size", CMD_SIZE, mon_e.size);
            $display("pop addr=0x%08h size=%0d level=%0d", CMD_ADDRESS, CMD_SIZE, CMD_LEVEL);
         end
      end
      CMD_RDEN = mon_rd;
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Called at posedge+1; returns one cycle after the first push edge.
   task automatic do_start(input logic [31:0] b, input logic [63:0] s, input logic [31:0] st,
                           input logic [31:0] c, input int n_exp);
      cmd_t e;
      logic [31:0] a;
      BASE_ADDR = b; PKT_SIZE = s; PKT_STRIDE = st; PKT_COUNT = c; START = 1'b1;
      a = b;
      for (int i = 0; i < n_exp; i++) begin
         e.addr = a;
         e.size = s;
         exp_q.push_back(e);
         a = a + st;
      end
      $display("start base=0x%08h size=%0d stride=0x%0h count=%0d", b, s, st, c);
      tick();
      START = 1'b0;
      BASE_ADDR = $urandom; PKT_SIZE = {$urandom, $urandom};
      PKT_STRIDE = $urandom; PKT_COUNT = $urandom;
      check("busy_after_start", 64'(GEN_BUSY), 64'd1);
      check("empty_before_push", 64'(CMD_EMPTY), 64'd1);
      check("issued_cleared", 64'(ISSUED_COUNT), 64'd0);
      check("done_cleared", 64'(DONE_COUNT), 64'd0);
      tick();
      check("empty_after_first_push", 64'(CMD_EMPTY), 64'd0);
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget; i++) begin
         tick();
         if (!GEN_BUSY) break;
      end
      check("gen_busy_falls", 64'(GEN_BUSY), 64'd0);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_empty"}, 64'(CMD_EMPTY), 64'd1);
      check({tag, "_addr"}, 64'(CMD_ADDRESS), 64'd0);
      check({tag, "_size"}, CMD_SIZE, 64'd0);
      check({tag, "_level"}, 64'(CMD_LEVEL), 64'd0);
      check({tag, "_busy"}, 64'(GEN_BUSY), 64'd0);
      check({tag, "_issued"}, 64'(ISSUED_COUNT), 64'd0);
      check({tag, "_done"}, 64'(DONE_COUNT), 64'd0);
   endtask

   initial begin
      logic [31:0] c;
      RESET = 1'b1; START = 1'b0; STOP = 1'b0;
      BASE_ADDR = '0; PKT_SIZE = '0; PKT_STRIDE = '0; PKT_COUNT = '0;
      repeat (3) @(posedge CLK);
      #1 RESET = 1'b0;
      check_reset_outputs("reset");

      // Count mode with a reader that pops whenever non-empty
      pop_mode = 1;
      do_start(32'h1000, 64'd256, 32'h100, 32'd3, 3);
      wait_idle(100);
      check("count_issued", 64'(ISSUED_COUNT), 64'd3);
      check("count_done", 64'(DONE_COUNT), 64'd3);

      // Back-pressure: no pops until the FIFO saturates
      pop_mode = 0;
      do_start($urandom, {$urandom, $urandom}, $urandom, 32'd40, 40);
      repeat (20) tick();
      check("bp_level_full", 64'(CMD_LEVEL), 64'd16);
      check("bp_issued_16", 64'(ISSUED_COUNT), 64'd16);
      rden_manual = 1'b1; pop_mode = 3;
      tick();
      check("full_pop_level", 64'(CMD_LEVEL), 64'd15);
      check("full_pop_no_push", 64'(ISSUED_COUNT), 64'd16);
      rden_manual = 1'b0; pop_mode = 0;
      tick();
      check("refill_level", 64'(CMD_LEVEL), 64'd16);
      check("refill_issued", 64'(ISSUED_COUNT), 64'd17);
      pop_mode = 2;
      wait_idle(600);
      check("bp_issued_total", 64'(ISSUED_COUNT), 64'd40);
      check("bp_done_total", 64'(DONE_COUNT), 64'd40);

      // Continuous mode across the address wrap, STOP after five pushes
      pop_mode = 0;
      do_start(32'hFFFFFF00, {$urandom, $urandom}, 32'h100, 32'd0, 5);
      repeat (4) tick();
      check("wrap_level_5", 64'(CMD_LEVEL), 64'd5);
      STOP = 1'b1;
      tick();
      check("stop_issued", 64'(ISSUED_COUNT), 64'd5);
      check("stop_level", 64'(CMD_LEVEL), 64'd5);
      check("stop_drain_busy", 64'(GEN_BUSY), 64'd1);
      STOP = 1'b0;
      pop_mode = 1;
      wait_idle(100);
      check("wrap_done", 64'(DONE_COUNT), 64'd5);

      // Push and pop on one edge at level 5
      pop_mode = 0;
      do_start($urandom, {$urandom, $urandom}, $urandom, 32'd0, 6);
      repeat (4) tick();
      check("pp_level_before", 64'(CMD_LEVEL), 64'd5);
      rden_manual = 1'b1; pop_mode = 3;
      tick();
      check("pp_level_after", 64'(CMD_LEVEL), 64'd5);
      check("pp_issued", 64'(ISSUED_COUNT), 64'd6);
      rden_manual = 1'b0; pop_mode = 0; STOP = 1'b1;
      tick();
      check("pp_stop_issued", 64'(ISSUED_COUNT), 64'd6);
      STOP = 1'b0;
      pop_mode = 1;
      wait_idle(100);
      check("pp_done", 64'(DONE_COUNT), 64'd6);

      // STOP sampled on the edge of the final eligible push suppresses it
      pop_mode = 0;
      do_start($urandom, {$urandom, $urandom}, $urandom, 32'd4, 3);
      repeat (2) tick();
      STOP = 1'b1;
      tick();
      STOP = 1'b0;
      check("last_stop_issued", 64'(ISSUED_COUNT), 64'd3);
      check("last_stop_level", 64'(CMD_LEVEL), 64'd3);
      pop_mode = 1;
      wait_idle(100);

      // Zero size, START while busy, RDEN while empty, STOP while idle
      pop_mode = 0;
      do_start($urandom, 64'd0, $urandom, 32'd2, 2);
      tick();
      START = 1'b1; BASE_ADDR = $urandom; PKT_COUNT = 32'd7; PKT_SIZE = 64'd99;
      tick();
      START = 1'b0;
      check("busy_start_issued", 64'(ISSUED_COUNT), 64'd2);
      check("busy_start_level", 64'(CMD_LEVEL), 64'd2);
      pop_mode = 1;
      wait_idle(100);
      repeat (3) tick();
      check("empty_rden_level", 64'(CMD_LEVEL), 64'd0);
      check("empty_rden_done", 64'(DONE_COUNT), 64'd2);
      STOP = 1'b1;
      tick();
      STOP = 1'b0;
      check("idle_stop_busy", 64'(GEN_BUSY), 64'd0);

      // Asynchronous reset between edges with seven queued commands
      pop_mode = 0;
      do_start($urandom, {$urandom, $urandom}, $urandom, 32'd20, 0);
      repeat (6) tick();
      check("pre_reset_level", 64'(CMD_LEVEL), 64'd7);
      #3 RESET = 1'b1;
      #1;
      check_reset_outputs("async_reset");
      tick();
      RESET = 1'b0;
      exp_q.delete();
      pop_mode = 1;
      do_start(32'h2000, 64'd64, 32'h40, 32'd3, 3);
      wait_idle(100);
      check("post_reset_issued", 64'(ISSUED_COUNT), 64'd3);
      check("post_reset_done", 64'(DONE_COUNT), 64'd3);

      // Randomized runs with a random-pop reader
      for (int r = 0; r < 4; r++) begin
         c = 32'($urandom_range(1, 24));
         pop_mode = 2;
         do_start($urandom, {$urandom, $urandom}, $urandom, c, int'(c));
         wait_idle(1000);
         check("rand_issued", 64'(ISSUED_COUNT), 64'(c));
         check("rand_done", 64'(DONE_COUNT), 64'(c));
      end

      pop_mode = 0;
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/axi_memory_reader_cmd_gen.md
# axi_memory_reader_cmd_gen

Command generator that feeds the AXI memory reader its packet command stream. On a start pulse it issues a sequence of read commands: address, address+stride, and so on, each with a fixed byte size. The commands go into an internal first-word-fall-through command FIFO. The reader consumes that FIFO through the CMD_ADDRESS/CMD_SIZE/CMD_EMPTY/CMD_RDEN port set. Issue and completion counters are exported for status registers.

## Interface
- ADDR_WIDTH, 32, width of command address and stride
- FIFO_DEPTH, 16, command FIFO depth in entries; power of two, ≥2
- CLK  in  1  single clock
- RESET  in  1  asynchronous, active-high reset
- START  in  1  one-cycle start pulse; honoured only in IDLE
- STOP  in  1  level; ends generation early
- BASE_ADDR  in  ADDR_WIDTH  first packet address, latched on accepted START
- PKT_SIZE  in  64  bytes per packet, latched on accepted START; 0 is legal (reader emits stub)
- PKT_STRIDE  in  ADDR_WIDTH  address increment per packet, latched on accepted START
- PKT_COUNT  in  32  packets to issue, latched on accepted START; 0 = continuous until STOP
- CMD_ADDRESS  out  ADDR_WIDTH  head-of-FIFO address; 0 while CMD_EMPTY
- CMD_SIZE  out  64  head-of-FIFO size; 0 while CMD_EMPTY
- CMD_EMPTY  out  1  FIFO empty
- CMD_RDEN  in  1  pop strobe from reader; ignored while CMD_EMPTY
- CMD_LEVEL  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- GEN_BUSY  out  1  state != IDLE
- ISSUED_COUNT  out  32  commands pushed since last accepted START
- DONE_COUNT  out  32  commands popped since last accepted START

## Operation
- FSM states: IDLE, GENERATE, DRAIN.
- IDLE:
  - START=1 latches BASE_ADDR, PKT_SIZE, PKT_STRIDE and PKT_COUNT.
  - Loads next_addr=BASE_ADDR and remaining=PKT_COUNT.
  - Clears ISSUED_COUNT and DONE_COUNT.
  - Moves to GENERATE.
- GENERATE: one push per cycle when STOP=0 and CMD_LEVEL < FIFO_DEPTH.
  - Each push writes {next_addr, size}.
  - next_addr += stride, modulo 2^ADDR_WIDTH (wraps silently).
  - ISSUED_COUNT increments by 1.
  - If PKT_COUNT≠0, remaining decrements by 1.
- GENERATE -> DRAIN on either of:
  - A push that makes remaining reach 0 (count mode).
  - STOP=1 sampled in any cycle. STOP has priority: no push in that cycle.
- DRAIN: no pushes. Moves to IDLE on the cycle CMD_LEVEL==0.
- Pop: CMD_RDEN=1 with CMD_EMPTY=0 advances the read pointer and increments DONE_COUNT. With CMD_EMPTY=1 it has no effect and does not underflow.
- Push and pop in the same cycle leave CMD_LEVEL unchanged.
- Push eligibility uses the registered CMD_LEVEL. A pop from a full FIFO does not enable a push in the same cycle.
- START outside IDLE is ignored. STOP in IDLE is ignored.
- Parameter inputs are sampled only on an accepted START. Later changes do not affect the running sequence.
- Counters wrap at 2^32 without saturation.

## Timing
- Reset (asynchronous): state=IDLE, pointers and level=0, CMD_EMPTY=1, CMD_ADDRESS=0, CMD_SIZE=0, CMD_LEVEL=0, GEN_BUSY=0, ISSUED_COUNT=0, DONE_COUNT=0.
- Reset asserted mid-sequence discards all queued commands immediately; FIFO memory contents need no reset.
- All outputs are registered or decoded from registered state; there is no combinational path from CMD_RDEN to any output.
- Start latency: START sampled at edge k gives GEN_BUSY=1 after edge k. The first push happens at edge k+1, and CMD_EMPTY=0 with a valid head after edge k+1.
- FWFT: CMD_ADDRESS/CMD_SIZE show the next entry in the cycle after a pop edge, or go to 0 with CMD_EMPTY=1.
- Steady-state push rate: 1 command/cycle until full.
- GEN_BUSY falls the cycle after the final pop empties the FIFO in DRAIN.

## Test plan
- Count mode: BASE_ADDR=0x1000, PKT_SIZE=256, PKT_STRIDE=0x100, PKT_COUNT=3, CMD_RDEN pulsed whenever non-empty.
  - Heads seen: 0x1000, 0x1100, 0x1200, each with size 256.
  - Final ISSUED_COUNT=DONE_COUNT=3; GEN_BUSY falls after the last pop.
- Back-pressure: PKT_COUNT=40, FIFO_DEPTH=16, no pops.
  - CMD_LEVEL saturates at 16 after 16 pushes; ISSUED_COUNT=16.
  - After pops resume, all 40 addresses arrive in order with no gaps or duplicates.
- Wrap and continuous mode: ADDR_WIDTH=32, BASE_ADDR=0xFFFFFF00, PKT_STRIDE=0x100, PKT_COUNT=0.
  - Second head is 0x00000000.
  - STOP after 5 pushes: exactly 5 commands are issued, then DRAIN, then IDLE once empty.
- Zero size and ignored inputs:
  - PKT_SIZE=0, PKT_COUNT=2 gives two entries with CMD_SIZE=0.
  - START pulsed while busy changes no counters or addresses.
  - CMD_RDEN while empty leaves CMD_LEVEL=0 and DONE_COUNT unchanged.
- Simultaneous events:
  - Push and pop on the same edge at level 5 leaves level 5.
  - Pop at level 16 in GENERATE gives level 15 and no push that edge.
  - STOP coinciding with the last eligible push: that push is suppressed.
- Async reset: RESET asserted mid-edge-cycle with level 7.
  - Outputs take reset values before the next CLK edge.
  - After release, a new START runs cleanly from the new BASE_ADDR.
